spike_rate_monitor: RTL and testbench



---
 rtl/spike_rate_monitor.sv | 180 ++++++++++++++++++
 tb/tb_spike_rate_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_monitor.sv
// Windowed spike-rate, ISI and coincidence monitor for a pre/post spike pair.
// Optional ISI histogram bins are compiled in with SPIKE_MON_HIST_EN.
module spike_rate_monitor #(
  parameter int WINDOW = 200,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       freeze,
  input  logic [1:0] sel,
  output logic [7:0] stat_out,
  output logic       win_valid,
  output logic       isi_valid
`ifdef SPIKE_MON_HIST_EN
  ,
  input  logic [1:0] hist_sel,
  output logic [7:0] hist_out
`endif
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int XW = (CNT_W > 8) ? CNT_W : 8;
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW - 1);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t sat_inc(cnt_t v, logic en);
    if (en && (v != '1)) return v + cnt_t'(1);
    return v;
  endfunction

  logic [TW-1:0] timer_q, timer_d;
  cnt_t pre_q, pre_d;
  cnt_t post_q, post_d;
  cnt_t coi_q, coi_d;
  cnt_t pre_rate_q, pre_rate_d;
  cnt_t post_rate_q, post_rate_d;
  cnt_t coinc_q, coinc_d;
  cnt_t isi_q, isi_d;
  cnt_t last_isi_q, last_isi_d;
  logic primed_q, primed_d;
  logic isi_valid_q, isi_valid_d;
  logic win_q, win_d;
  logic [7:0] stat_q, stat_d;

  logic term;
  logic isi_load;
  cnt_t pre_inc, post_inc, coi_inc, isi_inc;
  cnt_t sel_val;
  logic [XW-1:0] sel_w;

  always_comb begin
    timer_d     = timer_q;
    pre_d       = pre_q;
    post_d      = post_q;
    coi_d       = coi_q;
    pre_rate_d  = pre_rate_q;
    post_rate_d = post_rate_q;
    coinc_d     = coinc_q;
    isi_d       = isi_q;
    last_isi_d  = last_isi_q;
    primed_d    = primed_q;
    isi_valid_d = isi_valid_q;
    win_d       = 1'b0;
    isi_load    = 1'b0;
    term        = (timer_q == T_LAST);
    pre_inc     = sat_inc(pre_q, pre_spike);
    post_inc    = sat_inc(post_q, post_spike);
    coi_inc     = sat_inc(coi_q, pre_spike & post_spike);
    isi_inc     = sat_inc(isi_q, 1'b1);

    unique case (sel)
      2'b00:   sel_val = pre_rate_q;
      2'b01:   sel_val = post_rate_q;
      2'b10:   sel_val = last_isi_q;
      default: sel_val = coinc_q;
    endcase
    sel_w  = XW'(sel_val);
    stat_d = sel_w[7:0];

    if (!freeze) begin
      timer_d = term ? '0 : timer_q + TW'(1);
      if (term) begin
        pre_rate_d  = pre_inc;
        post_rate_d = post_inc;
        coinc_d     = coi_inc;
        pre_d       = '0;
        post_d      = '0;
        coi_d       = '0;
        win_d       = 1'b1;
      end else begin
        pre_d  = pre_inc;
        post_d = post_inc;
        coi_d  = coi_inc;
      end
      // The first post spike only starts the interval measurement.
      if (post_spike) begin
        isi_d    = '0;
        primed_d = 1'b1;
        if (primed_q) begin
          last_isi_d  = isi_inc;
          isi_valid_d = 1'b1;
          isi_load    = 1'b1;
        end
      end else begin
        isi_d = isi_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q     <= '0;
      pre_q       <= '0;
      post_q      <= '0;
      coi_q       <= '0;
      pre_rate_q  <= '0;
      post_rate_q <= '0;
      coinc_q     <= '0;
      isi_q       <= '0;
      last_isi_q  <= '0;
      primed_q    <= 1'b0;
      isi_valid_q <= 1'b0;
      win_q       <= 1'b0;
      stat_q      <= '0;
    end else begin
      timer_q     <= timer_d;
      pre_q       <= pre_d;
      post_q      <= post_d;
      coi_q       <= coi_d;
      pre_rate_q  <= pre_rate_d;
      post_rate_q <= post_rate_d;
      coinc_q     <= coinc_d;
      isi_q       <= isi_d;
      last_isi_q  <= last_isi_d;
      primed_q    <= primed_d;
      isi_valid_q <= isi_valid_d;
      win_q       <= win_d;
      stat_q      <= stat_d;
    end
  end

  assign stat_out  = stat_q;
  assign win_valid = win_q;
  assign isi_valid = isi_valid_q;

`ifdef SPIKE_MON_HIST_EN
  logic [3:0][7:0] bin_q, bin_d;
  logic [7:0] hist_q, hist_d;
  logic [31:0] isi_w;
  logic [1:0] bidx;

  always_comb begin
    bin_d  = bin_q;
    hist_d = bin_q[hist_sel];
    isi_w  = 32'(isi_inc);
    if (isi_w <= 32'd3) bidx = 2'd0;
    else if (isi_w <= 32'd15) bidx = 2'd1;
    else if (isi_w <= 32'd63) bidx = 2'd2;
    else bidx = 2'd3;
    if (isi_load && (bin_q[bidx] != 8'hff))
      bin_d[bidx] = bin_q[bidx] + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      hist_q <= '0;
    end else begin
      bin_q  <= bin_d;
      hist_q <= hist_d;
    end
  end

  assign hist_out = hist_q;
`endif

endmodule

// File: tb/tb_spike_rate_monitor.sv
// Randomized self-checking bench for spike_rate_monitor (WINDOW=16 and 300).
// A timestamp-based reference model predicts every output each cycle.
module tb_spike_rate_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pre_spike = 1'b0;
  logic post_spike = 1'b0;
  logic freeze = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [7:0] so16, so300;
  logic wv16, wv300, iv16, iv300;
`ifdef SPIKE_MON_HIST_EN
  logic [1:0] hist_sel = 2'd0;
  logic [7:0] ho16, ho300;
`endif

  always #5 clk = ~clk;

  spike_rate_monitor #(.WINDOW(16), .CNT_W(8)) u_dut16 (
    .clk(clk), .rst(rst),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .freeze(freeze), .sel(sel),
    .stat_out(so16), .win_valid(wv16), .isi_valid(iv16)
`ifdef SPIKE_MON_HIST_EN
    , .hist_sel(hist_sel), .hist_out(ho16)
`endif
  );

  spike_rate_monitor #(.WINDOW(300), .CNT_W(8)) u_dut300 (
    .clk(clk), .rst(rst),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .freeze(freeze), .sel(sel),
    .stat_out(so300), .win_valid(wv300), .isi_valid(iv300)
`ifdef SPIKE_MON_HIST_EN
    , .hist_sel(hist_sel), .hist_out(ho300)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: active-cycle timestamps and plain integer counts.
  int W[2] = '{16, 300};
  int act[2], pc[2], qc[2], cc[2];
  int pr[2], qr[2], cr[2], li[2], lt[2], st[2];
  int hb[2][4], ho[2];
  bit iv[2], wv[2];

  function automatic int sat8(int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; pc[i] = 0; qc[i] = 0; cc[i] = 0;
      pr[i] = 0; qr[i] = 0; cr[i] = 0; li[i] = 0;
      lt[i] = -1; st[i] = 0; ho[i] = 0;
      iv[i] = 0; wv[i] = 0;
      for (int b = 0; b < 4; b++) hb[i][b] = 0;
    end
  endtask

  task automatic model_edge(bit p, bit q, bit f, int s, int hs);
    int t, isi, b;
    for (int i = 0; i < 2; i++) begin
      st[i] = (s == 0) ? pr[i] : (s == 1) ? qr[i] :
              (s == 2) ? li[i] : cr[i];
      ho[i] = hb[i][hs];
      wv[i] = 0;
      if (!f) begin
        t = act[i];
        act[i]++;
        pc[i] += p;
        qc[i] += q;
        cc[i] += (p && q);
        if (q) begin
          if (lt[i] >= 0) begin
            isi = sat8(t - lt[i]);
            li[i] = isi;
            iv[i] = 1;
            b = (isi <= 3) ? 0 : (isi <= 15) ? 1 : (isi <= 63) ? 2 : 3;
            hb[i][b] = sat8(hb[i][b] + 1);
          end
          lt[i] = t;
        end
        if (act[i] % W[i] == 0) begin
          pr[i] = sat8(pc[i]);
          qr[i] = sat8(qc[i]);
          cr[i] = sat8(cc[i]);
          pc[i] = 0; qc[i] = 0; cc[i] = 0;
          wv[i] = 1;
        end
      end
    end
  endtask

  task automatic step(bit p, bit q, bit f, int s, int hs);
    pre_spike = p;
    post_spike = q;
    freeze = f;
    sel = 2'(s);
`ifdef SPIKE_MON_HIST_EN
    hist_sel = 2'(hs);
`endif
    @(posedge clk);
    model_edge(p, q, f, s, hs);
    #1;
    check("stat16", so16, st[0]);
    check("win16", wv16, wv[0]);
    check("isiv16", iv16, iv[0]);
    check("stat300", so300, st[1]);
    check("win300", wv300, wv[1]);
    check("isiv300", iv300, iv[1]);
`ifdef SPIKE_MON_HIST_EN
    check("hist16", ho16, ho[0]);
    check("hist300", ho300, ho[1]);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_stat16", so16, 0);
    check("rst_win16", wv16, 0);
    check("rst_isiv16", iv16, 0);
    check("rst_stat300", so300, 0);
    check("rst_win300", wv300, 0);
    check("rst_isiv300", iv300, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pd, qd, r;
    model_reset();
    #2;
    do_reset();

    // Window 1: 5 pre, 3 post.
    for (int t = 0; t < 16; t++) begin
      step(t inside {1, 3, 5, 7, 9}, t inside {2, 6, 10}, 0,
           $urandom_range(0, 3), $urandom_range(0, 3));
      if (t == 14) check("d1_nowin", wv16, 0);
      if (t == 15) check("d1_win", wv16, 1);
    end
    step(0, 0, 0, 0, 0);
    check("d1_pre", so16, 5);
    check("d1_winclr", wv16, 0);
    step(0, 0, 0, 1, 0);
    check("d1_post", so16, 3);

    // ISI: post at 2, 9, 10.
    do_reset();
    for (int t = 0; t < 12; t++) begin
      step(0, t inside {2, 9, 10}, 0, 2, 0);
      if (t == 2) check("d2_prime", iv16, 0);
      if (t == 9) check("d2_isiv", iv16, 1);
      if (t == 10) check("d2_isi7", so16, 7);
      if (t == 11) check("d2_isi1", so16, 1);
    end

    // Coincidence incl. terminal cycle.
    do_reset();
    for (int t = 0; t < 32; t++) begin
      step(t inside {4, 15}, t inside {4, 15}, 0,
           (t == 16) ? 3 : (t == 17) ? 0 : (t == 18) ? 1 : 3, 0);
      if (t == 16) check("d3_coinc", so16, 2);
      if (t == 17) check("d3_pre", so16, 2);
      if (t == 18) check("d3_post", so16, 2);
    end
    step(0, 0, 0, 3, 0);
    check("d3_next", so16, 0);

    // Saturation over a 300-cycle window.
    do_reset();
    for (int t = 0; t < 302; t++) begin
      step(t < 300, 0, 0, 0, 0);
      if (t == 299) check("d4_win300", wv300, 1);
      if (t == 300) check("d4_sat", so300, 255);
      if (t == 300) check("d4_w16", so16, 16);
    end

    // Freeze delays window close by 10 cycles, then reset mid-window.
    do_reset();
    for (int t = 0; t < 30; t++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1),
           (t >= 5 && t < 15), $urandom_range(0, 3), 0);
      if (t == 15) check("d5_delayed", wv16, 0);
      if (t == 25) check("d5_close", wv16, 1);
    end
    for (int t = 0; t < 5; t++) step(1, 1, 0, 0, 0);
    do_reset();
    for (int t = 0; t < 20; t++) step(0, 0, 0, 0, 0);

    // Histogram pattern: post at 0, 2, 12, 80.
    do_reset();
    for (int t = 0; t < 82; t++)
      step(0, t inside {0, 2, 12, 80}, 0, 2, $urandom_range(0, 3));
`ifdef SPIKE_MON_HIST_EN
    step(0, 0, 0, 2, 0); check("h_bin0", ho16, 1);
    step(0, 0, 0, 2, 1); check("h_bin1", ho16, 1);
    step(0, 0, 0, 2, 2); check("h_bin2", ho16, 0);
    step(0, 0, 0, 2, 3); check("h_bin3", ho16, 1);
`endif

    // Random traffic with varying densities, freezes and resets.
    for (int blk = 0; blk < 25; blk++) begin
      pd = $urandom_range(0, 16);
      qd = (blk % 4 == 3) ? 0 : $urandom_range(0, 16);
      for (int t = 0; t < 200; t++) begin
        r = $urandom_range(0, 999);
        if (r == 0) do_reset();
        step($urandom_range(0, 15) < pd,
             (qd == 0) ? ($urandom_range(0, 399) == 0)
                       : ($urandom_range(0, 15) < qd),
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
